spi_reg_bridge: RTL and testbench

Upstream register-access stage for the TPU. Converts 16-bit SPI frames from the host MCU into the TPU's single-cycle register bus (addr, data_in, we), and serves register reads back over MISO. Runs on SYS_CLK and oversamples the SPI pins, so there is no SCK clock domain.

---
 rtl/spi_reg_bridge_pkg.sv | 20 ++
 rtl/spi_reg_bridge_sync_edge.sv | 37 +++
 rtl/spi_reg_bridge.sv | 199 +++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_reg_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int FRAME_BITS_DEF = 16;
   localparam int ADDR_BITS      = 8;
   localparam int RW_BIT         = 7;
   localparam int CNT_W          = $clog2(FRAME_BITS_DEF + 1);

   function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic bit_in);
      return {sr[6:0], bit_in};
   endfunction

endpackage

// File: rtl/spi_reg_bridge_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with one-cycle rise/fall pulses.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              prev_q;
   logic              prev_d;

   // Next value of the synchroniser chain and the edge-history flop.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   // Synchroniser and history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{1'b0}};
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// Oversampled mode-0 SPI slave that turns address/data frames into single-cycle
// register writes and read strobes, returning read data on MISO.
module spi_reg_bridge
   import spi_reg_bridge_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
   input  logic       SYS_CLK,
   input  logic       RST_N,
   input  logic       SPI_SCK,
   input  logic       SPI_CS_N,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO,
   output logic [7:0] addr,
   output logic [7:0] data_in,
   output logic       we,
   output logic       re,
   input  logic [7:0] rd_data,
   output logic       frame_err
);

   logic sck_rise_s;
   logic sck_fall_s;
   logic cs_rise_s;
   logic cs_fall_s;
   logic mosi_s;

   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_d;

   state_e           state_q,     state_d;
   logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
   logic [7:0]       sr_q,        sr_d;
   logic [7:0]       sr_next_s;
   logic             rw_q,        rw_d;
   logic [7:0]       addr_q,      addr_d;
   logic [7:0]       data_in_q,   data_in_d;
   logic             we_q,        we_d;
   logic             re_q,        re_d;
   logic             load_q,      load_d;
   logic [7:0]       tx_sr_q,     tx_sr_d;
   logic             miso_q,      miso_d;
   logic             frame_err_q, frame_err_d;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
      .clk   (SYS_CLK),
      .rst_n (RST_N),
      .d     (SPI_SCK),
      .rise  (sck_rise_s),
      .fall  (sck_fall_s)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clk   (SYS_CLK),
      .rst_n (RST_N),
      .d     (SPI_CS_N),
      .rise  (cs_rise_s),
      .fall  (cs_fall_s)
   );

   // MOSI only needs the same latency as SCK so it lines up with the rise pulse.
   always_comb begin
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
   end

   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sr_next_s = shift_in(sr_q, mosi_s);

   // Frame sequencing, bus strobes and MISO shifting.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      sr_d        = sr_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      data_in_d   = data_in_q;
      tx_sr_d     = load_q ? rd_data : tx_sr_q;
      miso_d      = miso_q;
      we_d        = 1'b0;
      re_d        = 1'b0;
      load_d      = re_q;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall_s) begin
               state_d   = ADDR;
               bit_cnt_d = {CNT_W{1'b0}};
               sr_d      = 8'h00;
            end else begin
               state_d   = IDLE;
            end
         end
         ADDR: begin
            miso_d = 1'b0;
            if (cs_rise_s) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else if (sck_rise_s) begin
               sr_d      = sr_next_s;
               bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (bit_cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                  addr_d  = {1'b0, sr_next_s[6:0]};
                  rw_d    = sr_next_s[RW_BIT];
                  re_d    = sr_next_s[RW_BIT];
                  tx_sr_d = 8'h00;
                  state_d = DATA;
               end else begin
                  state_d = ADDR;
               end
            end else begin
               state_d = ADDR;
            end
         end
         DATA: begin
            if (cs_rise_s) begin
               frame_err_d = 1'b1;
               miso_d      = 1'b0;
               state_d     = IDLE;
            end else if (sck_rise_s) begin
               sr_d      = sr_next_s;
               bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                  if (!rw_q) begin
                     data_in_d = sr_next_s;
                     we_d      = 1'b1;
                  end else begin
                     data_in_d = data_in_q;
                  end
                  miso_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  state_d = DATA;
               end
            end else if (sck_fall_s) begin
               miso_d  = tx_sr_q[7];
               tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end else begin
               state_d = DATA;
            end
         end
         DONE: begin
            miso_d = 1'b0;
            if (cs_rise_s) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            miso_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // All frame state and registered outputs.
   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         mosi_sync_q <= {SYNC_STAGES{1'b0}};
         state_q     <= IDLE;
         bit_cnt_q   <= {CNT_W{1'b0}};
         sr_q        <= 8'h00;
         rw_q        <= 1'b0;
         addr_q      <= 8'h00;
         data_in_q   <= 8'h00;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         load_q      <= 1'b0;
         tx_sr_q     <= 8'h00;
         miso_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         mosi_sync_q <= mosi_sync_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         sr_q        <= sr_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         data_in_q   <= data_in_d;
         we_q        <= we_d;
         re_q        <= re_d;
         load_q      <= load_d;
         tx_sr_q     <= tx_sr_d;
         miso_q      <= miso_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign SPI_MISO  = miso_q;
   assign addr      = addr_q;
   assign data_in   = data_in_q;
   assign we        = we_q;
   assign re        = re_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench: an SPI master drives frames while an event-level model
// predicts the write, read and abort strobes the bridge must produce.
module tb_spi_reg_bridge;

   localparam int HP = 8;

   logic       SYS_CLK  = 1'b0;
   logic       RST_N    = 1'b0;
   logic       SPI_SCK  = 1'b0;
   logic       SPI_CS_N = 1'b1;
   logic       SPI_MOSI = 1'b0;
   logic       SPI_MISO;
   logic [7:0] addr;
   logic [7:0] data_in;
   logic       we;
   logic       re;
   logic [7:0] rd_data  = 8'h00;
   logic       frame_err;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [15:0] exp_wr[$];
   logic [7:0]  exp_rd[$];
   int          exp_err     = 0;
   logic [7:0]  model_data  = 8'h00;
   logic [7:0]  rd_val      = 8'h00;
   logic        re_prev     = 1'b0;

   spi_reg_bridge dut (
      .SYS_CLK   (SYS_CLK),
      .RST_N     (RST_N),
      .SPI_SCK   (SPI_SCK),
      .SPI_CS_N  (SPI_CS_N),
      .SPI_MOSI  (SPI_MOSI),
      .SPI_MISO  (SPI_MISO),
      .addr      (addr),
      .data_in   (data_in),
      .we        (we),
      .re        (re),
      .rd_data   (rd_data),
      .frame_err (frame_err)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Register file stand-in: read data is only valid in the cycle after re.
   always @(posedge SYS_CLK) begin
      #1;
      rd_data = re_prev ? rd_val : ~rd_val;
      re_prev = re;
   end

   // Per-cycle comparison of the bus strobes against the predicted events.
   always @(negedge SYS_CLK) begin
      logic [15:0] ew;
      logic [7:0]  er;
      check("we_re_exclusive", {31'd0, we & re}, 32'd0);
      if (exp_wr.size() == 0) begin
         check("stray_we", {31'd0, we}, 32'd0);
      end else if (we) begin
         ew = exp_wr.pop_front();
         model_data = ew[7:0];
         check("we_addr", {24'd0, addr}, {24'd0, ew[15:8]});
         check("we_data", {24'd0, data_in}, {24'd0, ew[7:0]});
      end
      if (exp_rd.size() == 0) begin
         check("stray_re", {31'd0, re}, 32'd0);
      end else if (re) begin
         er = exp_rd.pop_front();
         check("re_addr", {24'd0, addr}, {24'd0, er});
      end
      if (exp_err == 0) begin
         check("stray_frame_err", {31'd0, frame_err}, 32'd0);
      end else if (frame_err) begin
         exp_err--;
      end
      check("data_in_hold", {24'd0, data_in}, {24'd0, model_data});
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge SYS_CLK);
      #1;
   endtask

   task automatic sck_bit(input logic b, output logic m);
      SPI_MOSI = b;
      wait_cyc(HP);
      m = SPI_MISO;
      SPI_SCK = 1'b1;
      wait_cyc(HP);
      SPI_SCK = 1'b0;
   endtask

   // One chip-select window of n SCK cycles; the model is told what must follow.
   task automatic frame(input logic [7:0] a, input logic [7:0] d, input int n,
                        input logic [7:0] rv, input int gap);
      logic [23:0] bits;
      logic [7:0]  cap;
      logic        m;
      bits   = {a, d, 8'($urandom)};
      rd_val = rv;
      if (n >= 8 && a[7]) exp_rd.push_back({1'b0, a[6:0]});
      if (n >= 16 && !a[7]) exp_wr.push_back({1'b0, a[6:0], d});
      if (n < 16) exp_err++;
      cap = 8'h00;
      SPI_CS_N = 1'b0;
      for (int i = 0; i < n; i++) begin
         sck_bit(bits[23-i], m);
         if (i >= 8 && i < 16) cap[15-i] = m;
      end
      wait_cyc(HP);
      SPI_CS_N = 1'b1;
      if (n >= 16) check("miso_byte", {24'd0, cap}, {24'd0, (a[7] ? rv : 8'h00)});
      wait_cyc(gap);
   endtask

   task automatic settle();
      wait_cyc(12);
      check("pending_we", exp_wr.size(), 32'd0);
      check("pending_re", exp_rd.size(), 32'd0);
      check("pending_err", exp_err, 32'd0);
      check("miso_idle", {31'd0, SPI_MISO}, 32'd0);
   endtask

   initial begin
      logic [23:0] bits;
      logic        m;
      int          sel;
      int          n;

      wait_cyc(3);
      check("rst_addr", {24'd0, addr}, 32'h00);
      check("rst_data_in", {24'd0, data_in}, 32'h00);
      check("rst_we_re", {30'd0, we, re}, 32'd0);
      check("rst_miso_err", {30'd0, SPI_MISO, frame_err}, 32'd0);
      RST_N = 1'b1;
      wait_cyc(3);

      frame(8'h21, 8'h64, 16, 8'h00, 8); settle();
      check("wr1_addr_lit", {24'd0, addr}, 32'h21);
      check("wr1_data_lit", {24'd0, data_in}, 32'h64);
      frame(8'h20, 8'h0F, 16, 8'h00, 8); settle();
      check("wr2_addr_lit", {24'd0, addr}, 32'h20);
      check("wr2_data_lit", {24'd0, data_in}, 32'h0F);
      frame(8'hA3, 8'h00, 16, 8'h10, 8); settle();
      check("rd_addr_lit", {24'd0, addr}, 32'h23);
      check("rd_data_in_kept", {24'd0, data_in}, 32'h0F);

      frame(8'h21, 8'h64, 16, 8'h00, 8); settle();
      frame(8'h22, 8'h32, 5, 8'h00, 8); settle();
      check("abort_data_lit", {24'd0, data_in}, 32'h64);
      check("abort_addr_lit", {24'd0, addr}, 32'h21);
      frame(8'h22, 8'h32, 16, 8'h00, 8); settle();
      check("after_abort_data_lit", {24'd0, data_in}, 32'h32);

      frame(8'h24, 8'h01, 20, 8'h00, 8); settle();
      check("overlong_addr_lit", {24'd0, addr}, 32'h24);
      check("overlong_data_lit", {24'd0, data_in}, 32'h01);

      // Reset during bit 10 of a write, then keep CS_N low across release.
      bits = {8'h25, 8'h55, 8'h00};
      SPI_CS_N = 1'b0;
      for (int i = 0; i < 9; i++) sck_bit(bits[23-i], m);
      SPI_MOSI = bits[14];
      wait_cyc(HP);
      SPI_SCK = 1'b1;
      wait_cyc(2);
      model_data = 8'h00;
      RST_N = 1'b0;
      #1;
      check("midrst_addr", {24'd0, addr}, 32'h00);
      check("midrst_data_in", {24'd0, data_in}, 32'h00);
      check("midrst_we_re", {30'd0, we, re}, 32'd0);
      check("midrst_miso_err", {30'd0, SPI_MISO, frame_err}, 32'd0);
      wait_cyc(HP);
      SPI_SCK = 1'b0;
      wait_cyc(2);
      RST_N = 1'b1;
      for (int i = 0; i < 8; i++) sck_bit(1'b1, m);
      wait_cyc(HP);
      SPI_CS_N = 1'b1;
      wait_cyc(8);
      settle();
      check("postrst_addr_lit", {24'd0, addr}, 32'h00);

      frame(8'h23, 8'h10, 16, 8'h00, 3);
      frame(8'h24, 8'h01, 16, 8'h00, 3);
      settle();
      check("b2b_addr_lit", {24'd0, addr}, 32'h24);
      check("b2b_data_lit", {24'd0, data_in}, 32'h01);

      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6) n = 16;
         else if (sel < 8) n = $urandom_range(17, 20);
         else n = $urandom_range(0, 15);
         frame(8'($urandom), 8'($urandom), n, 8'($urandom), $urandom_range(3, 10));
         settle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
